// File: rtl/cache_pkg.sv
// Shared types and widths for the direct-mapped write-through cache.
// IDX_W/TAG_W describe the default 16-line geometry.
package cache_pkg;

    localparam int ADDR_W    = 8;
    localparam int DATA_W    = 8;
    localparam int DEF_LINES = 16;
    localparam int IDX_W     = $clog2(DEF_LINES);
    localparam int TAG_W     = ADDR_W - IDX_W;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        WRITE,
        RESP
    } state_t;

endpackage

// File: rtl/cache_line_array.sv
// Valid/tag/data storage: combinational read on index, one synchronous write.
// Only the valid bits are reset; tag/data contents are don't-care until filled.
import cache_pkg::*;

module cache_line_array #(
    parameter int LINES = 16,
    parameter int IW    = 4,
    parameter int TW    = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [IW-1:0]     idx,
    output logic              rd_valid,
    output logic [TW-1:0]     rd_tag,
    output logic [DATA_W-1:0] rd_data,
    input  logic              we,
    input  logic              fill,
    input  logic [TW-1:0]     wr_tag,
    input  logic [DATA_W-1:0] wr_data
);

    logic [LINES-1:0]  valid_q;
    logic [TW-1:0]     tag_q  [LINES];
    logic [DATA_W-1:0] data_q [LINES];

    assign rd_valid = valid_q[idx];
    assign rd_tag   = tag_q[idx];
    assign rd_data  = data_q[idx];

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= '0;
        end else if (we && fill) begin
            valid_q[idx] <= 1'b1;
        end
    end

    // A write-hit refreshes data only; a fill also installs the tag.
    always_ff @(posedge clk) begin
        if (we) begin
            data_q[idx] <= wr_data;
            if (fill) begin
                tag_q[idx] <= wr_tag;
            end
        end
    end

endmodule

// File: rtl/cache_ctrl.sv
// Direct-mapped write-through cache controller with ready-based CPU stalls.
// Memory strobes, address and write data are registered from the next state.
import cache_pkg::*;

module cache_ctrl #(
    parameter int LINES    = 16,
    parameter int MEM_WAIT = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_read,
    input  logic              cpu_write,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ready,
    output logic              MMRead,
    output logic              MMWrite,
    output logic [ADDR_W-1:0] ABUS,
    output logic [DATA_W-1:0] CachetoMem,
    input  logic [DATA_W-1:0] MemtoCache,
    output logic [7:0]        hit_count,
    output logic [7:0]        miss_count
);

    localparam int IW = $clog2(LINES);
    localparam int TW = ADDR_W - IW;
    localparam int CW = (MEM_WAIT > 1) ? $clog2(MEM_WAIT) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(MEM_WAIT - 1);

    state_t            state_q, state_n;
    logic [CW-1:0]     cnt_q, cnt_n;
    logic [DATA_W-1:0] rdata_q;

    logic [IW-1:0]     idx;
    logic [TW-1:0]     tag;
    logic              line_valid;
    logic [TW-1:0]     line_tag;
    logic [DATA_W-1:0] line_data;
    logic              hit, is_wr, is_rd;
    logic              fill_we, hit_we;
    logic              arr_we;
    logic [DATA_W-1:0] arr_wdata;

    assign idx   = cpu_addr[IW-1:0];
    assign tag   = cpu_addr[ADDR_W-1:IW];
    assign hit   = line_valid && (line_tag == tag);
    assign is_wr = cpu_write;
    assign is_rd = cpu_read && !cpu_write;

    // Suppress array writes on a reset edge so an aborted fill leaves no line.
    assign arr_we    = (fill_we || hit_we) && !reset;
    assign arr_wdata = fill_we ? MemtoCache : cpu_wdata;

    cache_line_array #(
        .LINES(LINES),
        .IW   (IW),
        .TW   (TW)
    ) u_lines (
        .clk     (clk),
        .reset   (reset),
        .idx     (idx),
        .rd_valid(line_valid),
        .rd_tag  (line_tag),
        .rd_data (line_data),
        .we      (arr_we),
        .fill    (fill_we),
        .wr_tag  (tag),
        .wr_data (arr_wdata)
    );

    always_comb begin
        state_n   = state_q;
        cnt_n     = cnt_q;
        cpu_ready = 1'b0;
        fill_we   = 1'b0;
        hit_we    = 1'b0;
        unique case (state_q)
            IDLE: begin
                cpu_ready = !(is_rd || is_wr) || (is_rd && hit);
                if (is_wr) begin
                    state_n = WRITE;
                    cnt_n   = CNT_LOAD;
                    hit_we  = hit;
                end else if (is_rd && !hit) begin
                    state_n = FILL;
                    cnt_n   = CNT_LOAD;
                end
            end
            FILL: begin
                if (cnt_q == '0) begin
                    state_n = RESP;
                    fill_we = 1'b1;
                end else begin
                    cnt_n = cnt_q - 1'b1;
                end
            end
            WRITE: begin
                if (cnt_q == '0) begin
                    state_n = RESP;
                end else begin
                    cnt_n = cnt_q - 1'b1;
                end
            end
            RESP: begin
                cpu_ready = 1'b1;
                state_n   = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    assign cpu_rdata = (state_q == IDLE && hit) ? line_data : rdata_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            rdata_q    <= '0;
            MMRead     <= 1'b0;
            MMWrite    <= 1'b0;
            ABUS       <= '0;
            CachetoMem <= '0;
        end else begin
            state_q <= state_n;
            cnt_q   <= cnt_n;
            MMRead  <= (state_n == FILL);
            MMWrite <= (state_n == WRITE);
            if (fill_we) begin
                rdata_q <= MemtoCache;
            end
            if (state_n == FILL || state_n == WRITE) begin
                ABUS <= cpu_addr;
            end
            if (state_n == WRITE) begin
                CachetoMem <= cpu_wdata;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else if (state_q == IDLE && is_rd) begin
            if (hit && hit_count != 8'hFF) begin
                hit_count <= hit_count + 8'd1;
            end
            if (!hit && miss_count != 8'hFF) begin
                miss_count <= miss_count + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_cache_ctrl.sv
// Directed bench for cache_ctrl with a simple zero-latency memory model.
// Each access records its latency, strobe counts and read data.
module tb_cache_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       cpu_read, cpu_write;
    logic [7:0] cpu_addr, cpu_wdata;
    logic [7:0] cpu_rdata;
    logic       cpu_ready;
    logic       MMRead, MMWrite;
    logic [7:0] ABUS, CachetoMem, MemtoCache;
    logic [7:0] hit_count, miss_count;

    logic [7:0] mem [256] = '{8'h35: 8'hA7, 8'h45: 8'h33, default: 8'h00};

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    cache_ctrl #(
        .LINES   (16),
        .MEM_WAIT(2)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .cpu_read  (cpu_read),
        .cpu_write (cpu_write),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .cpu_ready (cpu_ready),
        .MMRead    (MMRead),
        .MMWrite   (MMWrite),
        .ABUS      (ABUS),
        .CachetoMem(CachetoMem),
        .MemtoCache(MemtoCache),
        .hit_count (hit_count),
        .miss_count(miss_count)
    );

    assign MemtoCache = mem[ABUS];

    always @(posedge clk) begin
        if (MMWrite) mem[ABUS] <= CachetoMem;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    int         a_cyc, a_rs, a_ws;
    logic [7:0] a_rdata, a_wd;
    logic       a_abus_ok;

    // Called just after a rising edge; returns just after the completing edge.
    task automatic access(input logic rd, input logic wr, input logic [7:0] addr,
                          input logic [7:0] wd);
        bit done = 0;
        cpu_read  = rd;
        cpu_write = wr;
        cpu_addr  = addr;
        cpu_wdata = wd;
        a_cyc = 0; a_rs = 0; a_ws = 0; a_rdata = '0; a_wd = '0; a_abus_ok = 1'b1;
        while (!done) begin
            @(negedge clk);
            if (MMRead) a_rs++;
            if (MMWrite) begin
                a_ws++;
                a_wd = CachetoMem;
            end
            if ((MMRead || MMWrite) && ABUS != addr) a_abus_ok = 1'b0;
            if (cpu_ready) begin
                a_rdata = cpu_rdata;
                done = 1;
            end else begin
                a_cyc++;
                if (a_cyc > 20) begin
                    chk("timeout", 32'(a_cyc), 32'd0);
                    done = 1;
                end
            end
        end
        @(posedge clk);
        #1;
        cpu_read  = 1'b0;
        cpu_write = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        cpu_read = 1'b0; cpu_write = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_ready", 32'(cpu_ready), 32'd1);
        chk("rst_strobes", {30'd0, MMRead, MMWrite}, 32'd0);
        chk("rst_abus", 32'(ABUS), 32'd0);
        chk("rst_c2m", 32'(CachetoMem), 32'd0);
        chk("rst_rdata", 32'(cpu_rdata), 32'd0);
        chk("rst_counts", {16'd0, hit_count, miss_count}, 32'd0);
        @(posedge clk); #1;

        access(1, 0, 8'h35, 8'h00);
        chk("miss_lat", 32'(a_cyc), 32'd3);
        chk("miss_rstb", 32'(a_rs), 32'd2);
        chk("miss_wstb", 32'(a_ws), 32'd0);
        chk("miss_abus", 32'(a_abus_ok), 32'd1);
        chk("miss_data", 32'(a_rdata), 32'hA7);
        chk("miss_cnt1", 32'(miss_count), 32'd1);

        access(1, 0, 8'h35, 8'h00);
        chk("hit_lat", 32'(a_cyc), 32'd0);
        chk("hit_rstb", 32'(a_rs), 32'd0);
        chk("hit_data", 32'(a_rdata), 32'hA7);
        chk("hit_cnt1", 32'(hit_count), 32'd1);

        access(0, 1, 8'h35, 8'h5C);
        chk("wr_lat", 32'(a_cyc), 32'd3);
        chk("wr_wstb", 32'(a_ws), 32'd2);
        chk("wr_rstb", 32'(a_rs), 32'd0);
        chk("wr_c2m", 32'(a_wd), 32'h5C);
        chk("wr_abus", 32'(a_abus_ok), 32'd1);
        chk("wr_mem", 32'(mem[8'h35]), 32'h5C);
        access(1, 0, 8'h35, 8'h00);
        chk("raw_lat", 32'(a_cyc), 32'd0);
        chk("raw_data", 32'(a_rdata), 32'h5C);
        chk("raw_hits", 32'(hit_count), 32'd2);

        access(0, 1, 8'h45, 8'h11);
        chk("wmiss_lat", 32'(a_cyc), 32'd3);
        chk("wmiss_mem", 32'(mem[8'h45]), 32'h11);
        access(1, 0, 8'h35, 8'h00);
        chk("alias_hit_lat", 32'(a_cyc), 32'd0);
        chk("alias_hit_data", 32'(a_rdata), 32'h5C);
        chk("alias_hits", 32'(hit_count), 32'd3);
        access(1, 0, 8'h45, 8'h00);
        chk("alias_miss_lat", 32'(a_cyc), 32'd3);
        chk("alias_miss_data", 32'(a_rdata), 32'h11);
        chk("alias_misses", 32'(miss_count), 32'd2);

        access(1, 1, 8'h10, 8'h22);
        chk("both_lat", 32'(a_cyc), 32'd3);
        chk("both_rstb", 32'(a_rs), 32'd0);
        chk("both_wstb", 32'(a_ws), 32'd2);
        chk("both_mem", 32'(mem[8'h10]), 32'h22);
        chk("both_counts", {16'd0, hit_count, miss_count}, {16'd0, 8'd3, 8'd2});

        // 0x45 now owns line 5, so this read misses and is aborted mid-fill.
        cpu_read = 1'b1;
        cpu_addr = 8'h35;
        @(posedge clk); #1;
        @(negedge clk);
        chk("abort_strobe_up", 32'(MMRead), 32'd1);
        #1 reset = 1'b1;
        cpu_read = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("abort_strobe_dn", 32'(MMRead), 32'd0);
        chk("abort_ready", 32'(cpu_ready), 32'd1);
        chk("abort_counts", {16'd0, hit_count, miss_count}, 32'd0);
        @(posedge clk); #1;
        access(1, 0, 8'h35, 8'h00);
        chk("post_abort_lat", 32'(a_cyc), 32'd3);
        chk("post_abort_data", 32'(a_rdata), 32'h5C);
        chk("post_abort_miss", 32'(miss_count), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
